// File: rtl/sample_load_ctrl.sv
// Frame-load sequencer: loader handshake -> 4-lane bank writes -> frame hold for the FFT core.
// Optional macro SAMPLE_LOAD_BITREV_EN: bank addresses in bit-reversed (decimation-in-time) order.

module sample_load_lane #(
  parameter int WORDSIZE = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [WORDSIZE-1:0] d,
  output logic [WORDSIZE-1:0] q
);
  logic [WORDSIZE-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (we) data_d = d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;
endmodule

module sample_load_ctrl #(
  parameter int WORDSIZE   = 16,
  parameter int NUMSAMPLES = 32,
  parameter int AW         = 3,
  parameter int TIMEOUT    = 64,
  parameter int FCW        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_req,
  output logic                ld_start,
  input  logic                ld_valid,
  input  logic [WORDSIZE-1:0] ld_data0,
  input  logic [WORDSIZE-1:0] ld_data1,
  input  logic [WORDSIZE-1:0] ld_data2,
  input  logic [WORDSIZE-1:0] ld_data3,
  input  logic                ld_done,
  input  logic                ld_error,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [WORDSIZE-1:0] wr_data0,
  output logic [WORDSIZE-1:0] wr_data1,
  output logic [WORDSIZE-1:0] wr_data2,
  output logic [WORDSIZE-1:0] wr_data3,
  output logic                frame_ready,
  input  logic                core_ack,
  output logic                busy,
  output logic                err,
  input  logic                clr_err,
  output logic [FCW-1:0]      frame_count
);
  localparam int NUM_LANES = 4;
  localparam int BEATS     = NUMSAMPLES / NUM_LANES;
  localparam int CW        = AW + 1;
  localparam int TW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);
  localparam logic [TW-1:0] TMO_C   = TW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY, S_ERR} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic [FCW-1:0]       frame_count_q, frame_count_d;
  logic                 ld_start_q, ld_start_d;
  logic                 frame_ready_q, frame_ready_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 wr_en_q, wr_en_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [AW-1:0]        beat_addr;
  logic                 wr_fire;

  logic [NUM_LANES-1:0][WORDSIZE-1:0] ld_lanes, wr_lanes;

`ifdef SAMPLE_LOAD_BITREV_EN
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction
  assign beat_addr = bitrev(beat_cnt_q[AW-1:0]);
`else
  assign beat_addr = beat_cnt_q[AW-1:0];
`endif

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    frame_count_d = frame_count_q;
    wr_fire       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A done level left over from the previous frame must drop before restarting.
        if (frame_req && !ld_done) begin
          state_d    = S_LOAD;
          beat_cnt_d = '0;
          tmo_cnt_d  = '0;
        end
      end
      S_LOAD: begin
        if (ld_error) begin
          state_d = S_ERR;
        end else if (ld_valid && beat_cnt_q == BEATS_C) begin
          state_d = S_ERR;
        end else begin
          if (ld_valid) begin
            wr_fire    = 1'b1;
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
          // Count includes a final beat arriving together with done.
          if (ld_done) state_d = (beat_cnt_d == BEATS_C) ? S_READY : S_ERR;
          if (ld_valid || ld_done) begin
            tmo_cnt_d = '0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (tmo_cnt_d == TMO_C) state_d = S_ERR;
          end
        end
      end
      S_READY: begin
        if (core_ack) begin
          state_d       = S_IDLE;
          frame_count_d = frame_count_q + 1'b1;
        end
      end
      S_ERR: begin
        if (clr_err) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ERR) begin
      beat_cnt_d = '0;
      tmo_cnt_d  = '0;
    end

    ld_start_d    = (state_d == S_LOAD);
    frame_ready_d = (state_d == S_READY);
    busy_d        = (state_d != S_IDLE);
    err_d         = (state_d == S_ERR);
    wr_en_d       = wr_fire;
    wr_addr_d     = wr_fire ? beat_addr : wr_addr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      beat_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      frame_count_q <= '0;
      ld_start_q    <= 1'b0;
      frame_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      frame_count_q <= frame_count_d;
      ld_start_q    <= ld_start_d;
      frame_ready_q <= frame_ready_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
    end
  end

  assign ld_lanes = {ld_data3, ld_data2, ld_data1, ld_data0};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sample_load_lane #(.WORDSIZE(WORDSIZE)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (wr_fire),
      .d    (ld_lanes[g]),
      .q    (wr_lanes[g])
    );
  end

  assign wr_data0    = wr_lanes[0];
  assign wr_data1    = wr_lanes[1];
  assign wr_data2    = wr_lanes[2];
  assign wr_data3    = wr_lanes[3];
  assign ld_start    = ld_start_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign frame_ready = frame_ready_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_sample_load_ctrl.sv
// Bench for sample_load_ctrl: frame scenario table, hand-written corner sequences, random frames
// against a scoreboard of expected bank writes and frame outcomes.

module tb_sample_load_ctrl;
  localparam int WS = 16, NS = 32, AW = 3, TMO = 64, FCW = 8, NB = NS / 4;

  logic clk = 1'b0, rst_n = 1'b0, frame_req = 1'b0, ld_valid = 1'b0, ld_done = 1'b0;
  logic ld_error = 1'b0, core_ack = 1'b0, clr_err = 1'b0;
  logic [WS-1:0] ld_data0 = '0, ld_data1 = '0, ld_data2 = '0, ld_data3 = '0;
  logic ld_start, wr_en, frame_ready, busy, err;
  logic [AW-1:0] wr_addr;
  logic [WS-1:0] wr_data0, wr_data1, wr_data2, wr_data3;
  logic [FCW-1:0] frame_count;

  always #5 clk = ~clk;

  sample_load_ctrl #(.WORDSIZE(WS), .NUMSAMPLES(NS), .AW(AW), .TIMEOUT(TMO), .FCW(FCW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_req(frame_req), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data0(ld_data0), .ld_data1(ld_data1), .ld_data2(ld_data2), .ld_data3(ld_data3),
    .ld_done(ld_done), .ld_error(ld_error), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_data2(wr_data2), .wr_data3(wr_data3),
    .frame_ready(frame_ready), .core_ack(core_ack), .busy(busy), .err(err),
    .clr_err(clr_err), .frame_count(frame_count)
  );

  typedef struct {
    logic [AW-1:0]   addr;
    logic [4*WS-1:0] data;
    int              stamp;
  } wr_t;

  typedef struct {
    int nbeats;
    bit done_last;
    int err_at;
    bit exp_ready;
  } vec_t;

  wr_t exp_q[$];
  int n_cmp = 0, n_err = 0, cyc = 0, fc_model = 0;
  logic [AW-1:0] rev_tab [NB] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock; any bank write seen must match the oldest expected write.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) chk("wr_unexpected", wr_en, 0);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", {wr_data3, wr_data2, wr_data1, wr_data0}, e.data);
        chk("wr_latency", cyc, e.stamp);
      end
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input int i);
`ifdef SAMPLE_LOAD_BITREV_EN
    return rev_tab[i];
`else
    return AW'(i);
`endif
  endfunction

  task automatic set_beat(input int i, input bit rnd, input bit expect_wr);
    logic [WS-1:0] d [4];
    wr_t e;
    for (int k = 0; k < 4; k++) d[k] = rnd ? WS'($urandom) : WS'(256 * k + i);
    {ld_data3, ld_data2, ld_data1, ld_data0} = {d[3], d[2], d[1], d[0]};
    ld_valid = 1'b1;
    if (expect_wr) begin
      e.addr  = exp_addr(i);
      e.data  = {d[3], d[2], d[1], d[0]};
      e.stamp = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_frame(input int nbeats, input bit done_last, input int err_at,
                           input int gap_max, input bit rnd, input bit started, input bit exp_ready);
    bit stop;
    stop = 1'b0;
    if (!started) begin frame_req = 1'b1; tick(); frame_req = 1'b0; end
    chk("ld_start_up", ld_start, 1);
    chk("busy_load", busy, 1);
    for (int i = 0; i < nbeats && !stop; i++) begin
      repeat ($urandom_range(gap_max, 0)) tick();
      if (i == err_at) begin set_beat(i, rnd, 1'b0); ld_error = 1'b1; stop = 1'b1; end
      else if (i >= NB) begin set_beat(i, rnd, 1'b0); stop = 1'b1; end
      else set_beat(i, rnd, 1'b1);
      if (done_last && i == nbeats - 1 && !stop) ld_done = 1'b1;
      tick();
      ld_valid = 1'b0;
      ld_error = 1'b0;
    end
    if (!stop && !ld_done) begin
      repeat ($urandom_range(gap_max, 0)) tick();
      ld_done = 1'b1;
      tick();
    end
    chk("frame_ready", frame_ready, exp_ready);
    chk("err_flag", err, !exp_ready);
    chk("ld_start_down", ld_start, 0);
    ld_done = 1'b0;
    repeat ($urandom_range(3, 0)) tick();
    if (exp_ready) begin
      chk("ready_hold", frame_ready, 1);
      core_ack = 1'b1; tick(); core_ack = 1'b0;
      fc_model = (fc_model + 1) % 256;
      chk("ready_clr", frame_ready, 0);
    end else begin
      chk("err_hold", err, 1);
      chk("ready_never", frame_ready, 0);
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      chk("err_clr", err, 0);
    end
    chk("busy_idle", busy, 0);
    chk("frame_count", frame_count, fc_model);
    chk("writes_drained", exp_q.size(), 0);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{8, 0, -1, 1};  // normal frame, done after last beat
    vecs[1] = '{8, 1, -1, 1};  // done together with final beat
    vecs[2] = '{5, 0, -1, 0};  // short frame
    vecs[3] = '{0, 0, -1, 0};  // done with no beats
    vecs[4] = '{9, 0, -1, 0};  // extra beat past frame end
    vecs[5] = '{8, 0,  3, 0};  // loader error mid-frame
    vecs[6] = '{7, 1, -1, 0};  // short frame, done on last beat
    vecs[7] = '{8, 0,  7, 0};  // loader error on final beat

    // Reset state
    repeat (2) tick();
    chk("rst_ld_start", ld_start, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", {wr_data3, wr_data2, wr_data1, wr_data0}, 0);
    chk("rst_ready", frame_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_fcount", frame_count, 0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a load
    frame_req = 1'b1; tick(); frame_req = 1'b0;
    for (int i = 0; i < 3; i++) begin set_beat(i, 1'b0, 1'b1); tick(); ld_valid = 1'b0; end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mid_rst_ld_start", ld_start, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fcount", frame_count, fc_model);
    chk("mid_rst_drained", exp_q.size(), 0);
    run_frame(8, 0, -1, 0, 1'b0, 1'b0, 1'b1);

    // Scenario table
    for (int v = 0; v < 8; v++)
      run_frame(vecs[v].nbeats, vecs[v].done_last, vecs[v].err_at, 2, 1'b0, 1'b0, vecs[v].exp_ready);

    // Stall: 63 idle cycles tolerated, 64 idle cycles is an error
    frame_req = 1'b1; tick(); frame_req = 1'b0;
    repeat (TMO - 1) tick();
    chk("stall63_noerr", err, 0);
    chk("stall63_start", ld_start, 1);
    set_beat(0, 1'b0, 1'b1); tick(); ld_valid = 1'b0;
    chk("stall_beat_noerr", err, 0);
    repeat (TMO - 1) tick();
    chk("stall_pre_err", err, 0);
    tick();
    chk("stall64_err", err, 1);
    chk("stall64_start", ld_start, 0);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("stall_clr", err, 0);
    chk("stall_drained", exp_q.size(), 0);

    // Backpressure: held frame_req and ld_done must not start a load
    frame_req = 1'b1; tick();
    chk("bp_start", ld_start, 1);
    for (int i = 0; i < NB; i++) begin
      set_beat(i, 1'b1, 1'b1);
      if (i == NB - 1) ld_done = 1'b1;
      tick();
      ld_valid = 1'b0;
    end
    chk("bp_ready", frame_ready, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_no_start", ld_start, 0);
      chk("bp_hold_ready", frame_ready, 1);
    end
    core_ack = 1'b1; tick(); core_ack = 1'b0;
    fc_model = (fc_model + 1) % 256;
    chk("bp_ack_ready", frame_ready, 0);
    chk("bp_ack_fcount", frame_count, fc_model);
    for (int i = 0; i < 3; i++) begin tick(); chk("bp_wait_done", ld_start, 0); end
    ld_done = 1'b0; tick();
    chk("bp_restart", ld_start, 1);
    frame_req = 1'b0;
    run_frame(8, 0, -1, 2, 1'b1, 1'b1, 1'b1);

    // Random frames against the outcome model
    for (int f = 0; f < 40; f++) begin
      int nb, ea;
      bit dl;
      nb = ($urandom_range(1, 0) == 1) ? NB : int'($urandom_range(NB + 1, 0));
      dl = 1'($urandom_range(1, 0));
      ea = (nb > 0 && $urandom_range(5, 0) == 0) ? int'($urandom_range(nb - 1, 0)) : -1;
      run_frame(nb, dl, ea, 4, 1'b1, 1'b0, (ea < 0) && (nb == NB));
    end

    // Frame counter wraps after 256 completed frames
    begin
      int fc0;
      fc0 = fc_model;
      for (int f = 0; f < 256; f++) run_frame(8, 1, -1, 0, 1'b1, 1'b0, 1'b1);
      chk("fcount_wrap", frame_count, fc0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sample_load_ctrl.md
Name: sample_load_ctrl

Overview:
- Sequences one frame load from the 4-lane sample loader into four sample-bank RAMs feeding the FFT core.
- Drives the loader's start/done handshake and counts 4-word beats.
- Generates bank write strobes and addresses, checks beat count and timeout, then holds the frame for the core until it is acknowledged.
- Sits between the sample loader and the FFT core's input banks.

Parameters:
WORDSIZE, 16, bits per sample word
NUMSAMPLES, 32, samples per frame; multiple of 4, power of 2
AW, 3, bank address width = log2(NUMSAMPLES/4)
TIMEOUT, 64, max cycles without loader progress before error
FCW, 8, frame counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
frame_req  in  1  upstream requests a new frame load (level)
ld_start  out  1  start level to loader; held for whole load
ld_valid  in  1  loader presents a 4-word beat this cycle
ld_data0..ld_data3  in  WORDSIZE each  loader lanes 0..3
ld_done  in  1  loader finished (level, stays high until ld_start drops)
ld_error  in  1  loader error
wr_en  out  1  bank write strobe (all four banks)
wr_addr  out  AW  bank address
wr_data0..wr_data3  out  WORDSIZE each  bank k write data
frame_ready  out  1  complete frame resident in banks
core_ack  in  1  FFT core has consumed frame
busy  out  1  state != IDLE
err  out  1  sticky error flag
clr_err  in  1  clears err, returns ERR -> IDLE
frame_count  out  FCW  completed frames, wraps modulo 2^FCW

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; all outputs 0; beat_cnt, timeout counter, frame_count = 0. Reset mid-load aborts immediately: ld_start=0 next cycle, no further wr_en.
- States: IDLE, LOAD, READY, ERR.
- IDLE: frame_req=1 and ld_done=0 -> LOAD, ld_start=1 from next cycle. If ld_done is still high from the prior frame, wait in IDLE.
- LOAD: ld_start=1.
  - Each ld_valid with beat_cnt < NUMSAMPLES/4: next cycle wr_en=1, wr_addr=beat_cnt, wr_dataK=ld_dataK; beat_cnt++. Write latency is exactly 1 cycle.
  - Bank k address a holds sample a + k*NUMSAMPLES/4.
  - ld_done with beat_cnt == NUMSAMPLES/4 (including final beat in same cycle as ld_done) -> READY.
  - ld_done with fewer beats -> ERR.
  - ld_valid with beat_cnt == NUMSAMPLES/4 -> ERR; that beat is not written.
  - ld_error=1 -> ERR, with priority over all other events.
  - Timeout counter clears on each ld_valid or ld_done and increments otherwise; reaching TIMEOUT -> ERR.
- READY: ld_start=0; frame_ready=1; wr_en=0. core_ack=1 -> IDLE, frame_ready=0 next cycle, frame_count++.
  - frame_req is ignored in READY; a new load never overwrites an unacknowledged frame.
  - core_ack outside READY is ignored.
- ERR: err=1, ld_start=0, frame_ready=0, wr_en=0, beat_cnt=0. clr_err=1 -> IDLE, err=0 next cycle. If clr_err and frame_req are both high, the restart takes one extra cycle via IDLE.
- busy=1 in LOAD, READY, ERR.
- beat_cnt clears on entry to LOAD.
- All outputs are registered.

Optional Feature:
- Macro SAMPLE_LOAD_BITREV_EN.
- Defined: wr_addr = bit-reverse of beat_cnt over AW bits, giving decimation-in-time input order. For NUMSAMPLES=32: beats 0..7 -> addr 0,4,2,6,1,5,3,7.
- Undefined: wr_addr = beat_cnt in natural order. All other behaviour is identical.

Test Plan:
- Normal frame: rst_n low 2 cycles, frame_req=1, loader gives 8 consecutive beats (lane k = 16'h0100*k + beat) then ld_done.
  - Required: 8 wr_en pulses at addr 0..7, each one cycle after its ld_valid, with data matching.
  - Required: frame_ready=1 after ld_done; core_ack -> frame_count=1, busy=0.
- Short frame: ld_done after 5 beats -> err=1, ld_start=0, frame_ready never set; clr_err -> IDLE, err=0.
- Stall: ld_start high with no ld_valid/ld_done for 64 cycles -> err=1 on the 64th cycle; with 63 idle cycles then a beat, no error.
- Backpressure: frame_req held high through READY for 20 cycles without core_ack -> no ld_start and no wr_en; after core_ack, the next load starts only once ld_done is low.
- Reset mid-load after beat 3 -> next cycle ld_start=0, wr_en=0, frame_count unchanged; a fresh frame then loads addr 0..7 correctly.
- With SAMPLE_LOAD_BITREV_EN: normal frame -> wr_addr sequence 0,4,2,6,1,5,3,7; frame_count wraps 255 -> 0 after 256 frames.
